// File: rtl/mmio_uart_tx_pkg.sv
// mmio_uart_tx_pkg: definitions shared by the MMIO UART transmitter.
// Register offsets (word index AddressBus[3:2]), STATUS bit positions, the
// ControlBus field layout (shared with the CPU and DataMemory), the bus
// request bundle and the transmit FSM state encoding.
package mmio_uart_tx_pkg;

    // Register word offsets within the 16-byte window
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    // STATUS bit positions
    localparam int STB_BUSY      = 0;
    localparam int STB_FULL      = 1;
    localparam int STB_EMPTY     = 2;
    localparam int STB_OVF       = 3;
    localparam int STB_PARITY    = 4;
    localparam int STB_COUNT_LSB = 8;

    // ControlBus field positions
    localparam int CB_MEM_READ  = 1;
    localparam int CB_MEM_WRITE = 2;
    localparam int CB_LOAD_LSB  = 3;
    localparam int CB_LOAD_MSB  = 6;
    localparam int CB_STORE_LSB = 7;
    localparam int CB_STORE_MSB = 10;

    // Decoded CPU access to this responder
    typedef struct packed {
        logic        sel;
        logic        rdEn;
        logic        wrEn;
        logic [1:0]  offset;
        logic [31:0] wdata;
    } busReq_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } txState_t;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-high reset.
// Ports: clk, rst; push/wrData write side; pop/rdData read side
// (rdData shows the head entry combinationally); full, empty, count.
// A push while full is dropped unless a pop happens in the same cycle;
// a pop while empty is ignored. DEPTH must be a power of 2.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign doPop  = pop && !empty;
    // The slot freed by a simultaneous pop makes room for the push
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the CPU data-memory bus.
// Ports: InputClk, rst (sync, active high); AddressBus/DataIn/ControlBus
// from the CPU; DataOut load data (0 when not selected, OR-mergeable);
// tx serial line (idle high); tx_idle_irq (FIFO empty and FSM idle).
// Registers: +0 TXDATA (W), +4 STATUS (R, W1C overflow), +8 BAUDDIV (R/W).
// Build option: UART_TX_PARITY_EN adds an even-parity bit before STOP
// and sets STATUS[4].
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_1000,
    parameter int          FIFO_DEPTH       = 8,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd16
) (
    input  logic        InputClk,
    input  logic        rst,
    input  logic [31:0] AddressBus,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    input  logic [10:0] ControlBus,
    output logic        tx,
    output logic        tx_idle_irq
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam logic HAS_PARITY = 1'b1;
`else
    localparam logic HAS_PARITY = 1'b0;
`endif

    busReq_t          req;
    logic             pushReq;
    logic             wrStatus;
    logic             wrBaud;
    logic [31:0]      statusWord;
    logic [15:0]      baudDiv;
    logic             overflow;

    logic             fifoPop;
    logic [7:0]       fifoData;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;

    txState_t         state, stateNext;
    logic             txReg, txNext;
    logic [15:0]      bitTimer, timerNext;
    logic [15:0]      curDiv, curDivNext;
    logic [2:0]       bitCnt, bitCntNext;
    logic [7:0]       shiftReg, shiftNext;
    logic             irqReg;
    logic             tick;
    logic             loadFrame;
`ifdef UART_TX_PARITY_EN
    logic             parityBit, parityNext;
`endif

    // Width/type qualifiers and sub-word address bits have no meaning here
    logic unusedBits;
    assign unusedBits = ^{ControlBus[CB_STORE_MSB:CB_STORE_LSB],
                          ControlBus[CB_LOAD_MSB:CB_LOAD_LSB], ControlBus[0],
                          AddressBus[1:0], DataIn[31:16]};

    // ---------------- bus decode ----------------
    assign req.sel    = (AddressBus[31:4] == BASE_ADDR[31:4]);
    assign req.rdEn   = ControlBus[CB_MEM_READ];
    assign req.wrEn   = ControlBus[CB_MEM_WRITE];
    assign req.offset = AddressBus[3:2];
    assign req.wdata  = DataIn;

    assign pushReq  = req.sel && req.wrEn && (req.offset == REG_TXDATA);
    assign wrStatus = req.sel && req.wrEn && (req.offset == REG_STATUS);
    assign wrBaud   = req.sel && req.wrEn && (req.offset == REG_BAUDDIV);

    always_comb begin
        statusWord                              = '0;
        statusWord[STB_BUSY]                    = (state != ST_IDLE);
        statusWord[STB_FULL]                    = fifoFull;
        statusWord[STB_EMPTY]                   = fifoEmpty;
        statusWord[STB_OVF]                     = overflow;
        statusWord[STB_PARITY]                  = HAS_PARITY;
        statusWord[STB_COUNT_LSB +: CNT_W]      = fifoCount;
    end

    always_comb begin
        DataOut = '0;
        if (req.sel && req.rdEn) begin
            case (req.offset)
                REG_STATUS:  DataOut = statusWord;
                REG_BAUDDIV: DataOut = {16'h0000, baudDiv};
                default:     DataOut = '0;
            endcase
        end
    end

    always_ff @(posedge InputClk) begin
        if (rst) begin
            baudDiv  <= DEFAULT_BAUD_DIV;
            overflow <= 1'b0;
        end else begin
            // A divisor of 0 would stall the bit timer; clamp to 1
            if (wrBaud) baudDiv <= (req.wdata[15:0] == 16'd0) ? 16'd1 : req.wdata[15:0];
            if (pushReq && fifoFull && !fifoPop)           overflow <= 1'b1;
            else if (wrStatus && req.wdata[STB_OVF])       overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk    (InputClk),
        .rst    (rst),
        .push   (pushReq),
        .wrData (req.wdata[7:0]),
        .pop    (fifoPop),
        .rdData (fifoData),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (fifoCount)
    );

    // ---------------- transmit FSM ----------------
    always_ff @(posedge InputClk) begin
        if (rst) begin
            state    <= ST_IDLE;
            txReg    <= 1'b1;
            bitTimer <= '0;
            curDiv   <= DEFAULT_BAUD_DIV;
            bitCnt   <= '0;
            shiftReg <= '0;
            irqReg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            txReg    <= txNext;
            bitTimer <= timerNext;
            curDiv   <= curDivNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            irqReg   <= fifoEmpty && (state == ST_IDLE);
`ifdef UART_TX_PARITY_EN
            parityBit <= parityNext;
`endif
        end
    end

    // bitTimer counts down from divisor-1; each bit ends on the edge where it is 0
    assign tick = (bitTimer == 16'd0);

    always_comb begin
        stateNext  = state;
        txNext     = txReg;
        timerNext  = bitTimer;
        curDivNext = curDiv;
        bitCntNext = bitCnt;
        shiftNext  = shiftReg;
        fifoPop    = 1'b0;
        loadFrame  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parityNext = parityBit;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifoEmpty) loadFrame = 1'b1;
            end
            ST_START: begin
                if (tick) begin
                    stateNext  = ST_DATA;
                    txNext     = shiftReg[0];
                    timerNext  = curDiv - 16'd1;
                    bitCntNext = 3'd0;
                end else begin
                    timerNext = bitTimer - 16'd1;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    timerNext = curDiv - 16'd1;
                    if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        stateNext = ST_PARITY;
                        txNext    = parityBit;
`else
                        stateNext = ST_STOP;
                        txNext    = 1'b1;
`endif
                    end else begin
                        bitCntNext = bitCnt + 3'd1;
                        shiftNext  = {1'b0, shiftReg[7:1]};
                        txNext     = shiftReg[1];
                    end
                end else begin
                    timerNext = bitTimer - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    stateNext = ST_STOP;
                    txNext    = 1'b1;
                    timerNext = curDiv - 16'd1;
                end else begin
                    timerNext = bitTimer - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    // Chain straight into the next start bit when data waits
                    if (!fifoEmpty) loadFrame = 1'b1;
                    else            stateNext = ST_IDLE;
                end else begin
                    timerNext = bitTimer - 16'd1;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                txNext    = 1'b1;
            end
        endcase

        // Frame start: the divisor is captured here so later BAUDDIV
        // writes only affect the following frame.
        if (loadFrame) begin
            fifoPop    = 1'b1;
            shiftNext  = fifoData;
            curDivNext = baudDiv;
            timerNext  = baudDiv - 16'd1;
            txNext     = 1'b0;
            stateNext  = ST_START;
`ifdef UART_TX_PARITY_EN
            parityNext = ^fifoData;
`endif
        end
    end

    assign tx          = txReg;
    assign tx_idle_irq = irqReg;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized bench for mmio_uart_tx with a waveform-level
// reference model (per-cycle queue of expected line levels plus a byte queue)
// and a few hand-computed literal expectations.
module tb_mmio_uart_tx;
    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef UART_TX_PARITY_EN
    localparam int          NBITS = 11;
    localparam logic [31:0] PBIT  = 32'h10;
    localparam logic [10:0] A5_FRAME = 11'b1_0_10100101_0;
`else
    localparam int          NBITS = 10;
    localparam logic [31:0] PBIT  = 32'h0;
    localparam logic [10:0] A5_FRAME = 11'b0_1_10100101_0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] din = '0;
    logic [10:0] ctrl = '0;
    logic [31:0] dout;
    logic        tx;
    logic        irq;

    mmio_uart_tx dut (
        .InputClk    (clk),
        .rst         (rst),
        .AddressBus  (addr),
        .DataIn      (din),
        .DataOut     (dout),
        .ControlBus  (ctrl),
        .tx          (tx),
        .tx_idle_irq (irq)
    );

    always #5 clk = ~clk;

    int nCompared = 0;
    int nMismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mQ[$];      // bytes waiting in the FIFO
    bit          mWave[$];   // line level for each upcoming clock of the current frame
    logic [15:0] mBaud = 16'd16;
    bit          mOvf = 0, mBusy = 0, mTx = 1, mIrq = 1;

    task automatic addFrame(input logic [7:0] b, input logic [15:0] d);
        logic [10:0] bits;
`ifdef UART_TX_PARITY_EN
        bits = {1'b1, ^b, b, 1'b0};
`else
        bits = {1'b0, 1'b1, b, 1'b0};
`endif
        for (int i = 0; i < NBITS; i++)
            for (int j = 0; j < int'(d); j++) mWave.push_back(bits[i]);
    endtask

    function automatic logic [31:0] mStatus();
        logic [31:0] s;
        s       = PBIT;
        s[0]    = mBusy;
        s[1]    = (mQ.size() == DEPTH);
        s[2]    = (mQ.size() == 0);
        s[3]    = mOvf;
        s[15:8] = 8'(mQ.size());
        return s;
    endfunction

    function automatic logic [31:0] mRead(input logic [31:0] a, input logic [10:0] c);
        if (a[31:4] != BASE[31:4] || !c[1]) return 32'h0;
        case (a[3:2])
            2'd1:    return mStatus();
            2'd2:    return {16'h0, mBaud};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStep(input logic r, input logic [31:0] a, input logic [31:0] d,
                             input logic [10:0] c);
        bit idleEmpty, fullBefore, popped;
        if (r) begin
            mQ.delete(); mWave.delete();
            mBaud = 16'd16; mOvf = 0; mBusy = 0; mTx = 1; mIrq = 1;
            return;
        end
        idleEmpty  = (mQ.size() == 0) && !mBusy;
        fullBefore = (mQ.size() == DEPTH);
        popped     = 0;
        if (mWave.size() == 0 && mQ.size() != 0) begin
            addFrame(mQ.pop_front(), mBaud);
            popped = 1;
        end
        if (mWave.size() != 0) begin mTx = mWave.pop_front(); mBusy = 1; end
        else                   begin mTx = 1;                 mBusy = 0; end
        mIrq = idleEmpty;
        if (a[31:4] == BASE[31:4] && c[2]) begin
            case (a[3:2])
                2'd0: if (!fullBefore || popped) mQ.push_back(d[7:0]); else mOvf = 1;
                2'd1: if (d[3]) mOvf = 0;
                2'd2: mBaud = (d[15:0] == 16'd0) ? 16'd1 : d[15:0];
                default: ;
            endcase
        end
    endtask

    // Compare process: advance the model on each edge, check just after it
    always @(posedge clk) begin
        modelStep(rst, addr, din, ctrl);
        #1;
        chk("tx", {31'h0, tx}, {31'h0, mTx});
        chk("tx_idle_irq", {31'h0, irq}, {31'h0, mIrq});
        chk("DataOut", dout, mRead(addr, ctrl));
    end

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic rd, input logic wr);
        @(negedge clk);
        rst = r; addr = a; din = d; ctrl = {8'h00, wr, rd, 1'b0};
    endtask
    task automatic wrReg(input logic [1:0] off, input logic [31:0] d);
        drive(1'b0, BASE | {28'h0, off, 2'b00}, d, 1'b0, 1'b1);
    endtask
    task automatic rdReg(input logic [1:0] off);
        drive(1'b0, BASE | {28'h0, off, 2'b00}, 32'h0, 1'b1, 1'b0);
    endtask
    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask
    task automatic waitIdle();
        for (int k = 0; k < 3000; k++) begin
            idle();
            #1;
            if (irq === 1'b1) return;
        end
        nCompared++; nMismatched++;
        $display("FAIL waitIdle: irq still %b after 3000 cycles", irq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [10:0] frameLit;
    int          r;
    logic [1:0]  off;

    initial begin
        // Reset then idle
        repeat (3) drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        rdReg(2'd1); #1;
        chk("reset STATUS", dout, 32'h4 | PBIT);
        chk("reset tx", {31'h0, tx}, 32'h1);
        chk("reset irq", {31'h0, irq}, 32'h1);
        rdReg(2'd2); #1;
        chk("reset BAUDDIV", dout, 32'd16);

        // Single byte 0xA5 at 4 clocks/bit
        frameLit = A5_FRAME;
        wrReg(2'd2, 32'd4);
        wrReg(2'd0, 32'hA5);
        rdReg(2'd1);
        for (int k = 0; k < NBITS * 4; k++) begin
            @(posedge clk); #2;
            chk($sformatf("A5 frame clk %0d", k), {31'h0, tx}, {31'h0, frameLit[k / 4]});
            if (k == 5) chk("busy mid-frame", {31'h0, dout[0]}, 32'h1);
        end
        waitIdle();

        // Back-to-back frames at 2 clocks/bit
        wrReg(2'd2, 32'd2);
        wrReg(2'd0, 32'h55);
        wrReg(2'd0, 32'h0F);
        wrReg(2'd0, 32'hFF);
        rdReg(2'd1); #1;
        chk("b2b STATUS", dout, 32'h201 | PBIT);
        waitIdle();

        // Overflow with a stalled transmitter
        wrReg(2'd2, 32'h0000_FFFF);
        for (int i = 0; i < 10; i++) wrReg(2'd0, 32'h30 + i);
        rdReg(2'd1); #1;
        chk("overflow STATUS", dout, 32'h80B | PBIT);
        wrReg(2'd1, 32'h8);
        rdReg(2'd1); #1;
        chk("overflow cleared", dout, 32'h803 | PBIT);

        // Reset mid-frame
        drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        rdReg(2'd2); #1;
        chk("post-reset BAUDDIV", dout, 32'd16);
        chk("post-reset tx", {31'h0, tx}, 32'h1);
        chk("post-reset irq", {31'h0, irq}, 32'h1);
        rdReg(2'd1); #1;
        chk("post-reset STATUS", dout, 32'h4 | PBIT);

        // BAUDDIV of 0 clamps to 1
        wrReg(2'd2, 32'h0);
        rdReg(2'd2); #1;
        chk("BAUDDIV zero", dout, 32'd1);

        // Divisor change mid-frame only affects the next frame
        wrReg(2'd2, 32'd4);
        wrReg(2'd0, 32'h3C);
        wrReg(2'd0, 32'hC3);
        repeat (6) idle();
        wrReg(2'd2, 32'd8);
        waitIdle();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r   = $urandom_range(0, 99);
            off = 2'($urandom_range(0, 3));
            @(negedge clk);
            rst  = (r == 0);
            addr = BASE | 32'($urandom_range(0, 3));
            din  = $urandom;
            ctrl = 11'($urandom) & 11'h7F9;
            if (r < 40)      begin addr[3:2] = 2'd0; ctrl[2] = 1'b1; end
            else if (r < 46) begin addr[3:2] = 2'd2; ctrl[2] = 1'b1; end
            else if (r < 51) begin addr[3:2] = 2'd1; ctrl[2] = 1'b1; end
            else if (r < 54) begin addr[3:2] = 2'd3; ctrl[2] = 1'b1; end
            else if (r < 76) begin addr[3:2] = off;  ctrl[1] = 1'b1; end
            else if (r < 82) begin addr[3:2] = off;  ctrl[2:1] = 2'b11; end
            else if (r < 88) begin
                case ($urandom_range(0, 2))
                    0:       addr = 32'h0000_1010 | 32'($urandom_range(0, 15));
                    1:       addr = 32'h0000_0FF0 | 32'($urandom_range(0, 15));
                    default: addr = 32'h8000_1000 | 32'($urandom_range(0, 15));
                endcase
                ctrl[2:1] = 2'($urandom);
            end
            // Keep frames short so the FIFO fills and drains often
            if (addr[3:2] == 2'd2 && ctrl[2]) din[15:0] = 16'($urandom_range(0, 3));
        end
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
